// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter slice.
//   state_t         : measurement FSM states
//   PM_CNT_W        : default counter / output width
//   PM_SYNC_STAGES  : default synchronizer depth on sig_in
//   pm_sat_max()    : saturation ceiling (2^w - 1) for a w-bit counter
package period_meter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MEAS = 1'b1
   } state_t;

   localparam int unsigned PM_CNT_W       = 8;
   localparam int unsigned PM_SYNC_STAGES = 2;

   function automatic int unsigned pm_sat_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   localparam int unsigned PM_SAT_MAX = pm_sat_max(PM_CNT_W);

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes the asynchronous measured signal into the ip1 domain and
// produces single-cycle rise/fall strobes.
//   ip1    : clock, rising edge
//   reset  : synchronous, active-high; clears the chain and s_prev
//   sig_in : asynchronous input
//   rise   : s & ~s_prev
//   fall   : ~s & s_prev
module sync_edge_det
   import period_meter_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = PM_SYNC_STAGES
) (
   input  logic ip1,
   input  logic reset,
   input  logic sig_in,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_prev;

   always_ff @(posedge ip1) begin
      if (reset) begin
         sync_q <= '0;
         s_prev <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         s_prev <= s;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_prev;
   assign fall = ~s & s_prev;

endmodule

// File: rtl/period_meter.sv
// Measures period (rise-to-rise) and high time (rise-to-fall) of a slow
// square wave in ip1 cycles, presenting each result on a registered
// valid/ready output with sticky overflow/overrun flags.
//   ip1         : measurement clock, rising edge
//   reset       : synchronous, active-high
//   sig_in      : measured signal, asynchronous to ip1
//   meas_ready  : consumer accepts the measurement
//   clr_flags   : clears sticky flags (a same-cycle set wins)
//   meas_valid  : measurement available
//   meas_period : rise-to-rise period, saturating
//   meas_high   : rise-to-fall high time, saturating
//   overflow    : sticky, a count saturated
//   overrun     : sticky, a measurement was dropped
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = PM_CNT_W,
   parameter int unsigned SYNC_STAGES = PM_SYNC_STAGES
) (
   input  logic             ip1,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             meas_ready,
   input  logic             clr_flags,
   output logic             meas_valid,
   output logic [CNT_W-1:0] meas_period,
   output logic [CNT_W-1:0] meas_high,
   output logic             overflow,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(pm_sat_max(CNT_W));

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
   logic [CNT_W-1:0] high_hold, high_d;
   logic [CNT_W:0]   cnt_sum;
   logic             rise, fall;
   logic             at_max, capture, ovf_set, drop;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .ip1   (ip1),
      .reset (reset),
      .sig_in(sig_in),
      .rise  (rise),
      .fall  (fall)
   );

   always_comb begin
      // One extra bit so cnt+1 is seen before clamping to the ceiling.
      cnt_sum = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
      cnt_inc = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
      at_max  = (cnt == CNT_MAX);

      state_d = state;
      cnt_d   = cnt;
      high_d  = high_hold;
      capture = 1'b0;
      ovf_set = 1'b0;

      case (state)
         ST_IDLE: begin
            if (rise) begin
               cnt_d   = '0;
               state_d = ST_MEAS;
            end
         end
         ST_MEAS: begin
            cnt_d = cnt_inc;
            if (fall) begin
               high_d  = cnt_inc;
               ovf_set = at_max;
            end
            if (rise) begin
               capture = 1'b1;
               cnt_d   = '0;
               ovf_set = at_max;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      drop = capture & meas_valid & ~meas_ready;
   end

   always_ff @(posedge ip1) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         high_hold   <= '0;
         meas_valid  <= 1'b0;
         meas_period <= '0;
         meas_high   <= '0;
         overflow    <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         high_hold <= high_d;

         if (capture) begin
            // A pending result is replaced only if it is being taken now.
            if (!meas_valid || meas_ready) begin
               meas_period <= cnt_inc;
               meas_high   <= high_hold;
               meas_valid  <= 1'b1;
            end
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end

         overflow <= ovf_set | (overflow & ~clr_flags);
         overrun  <= drop    | (overrun  & ~clr_flags);
      end
   end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

   localparam int MAXV = 255;

   logic       ip1 = 1'b0;
   logic       reset, sig_in, meas_ready, clr_flags;
   logic       meas_valid, overflow, overrun;
   logic [7:0] meas_period, meas_high;

   period_meter #(
      .CNT_W      (8),
      .SYNC_STAGES(2)
   ) dut (
      .ip1        (ip1),
      .reset      (reset),
      .sig_in     (sig_in),
      .meas_ready (meas_ready),
      .clr_flags  (clr_flags),
      .meas_valid (meas_valid),
      .meas_period(meas_period),
      .meas_high  (meas_high),
      .overflow   (overflow),
      .overrun    (overrun)
   );

   always #5 ip1 = ~ip1;

   int n_assert = 0;
   int n_fail   = 0;
   int tick     = 0;
   always @(posedge ip1) tick++;

   typedef struct {
      int p;
      int h;
   } exp_t;
   exp_t q[$];

   // reference model state: edge times as driven, sticky flag expectations
   bit   armed = 0;
   int   last_rise = 0, last_fall = 0;
   bit   exp_ovf = 0, exp_ovr = 0;
   bit   stalled = 0, stall_busy = 0;
   bit   rdy_mode = 0;
   logic rdy_force = 1'b1;

   task automatic check(input string name, input int act, input int req);
      n_assert++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_assert++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic int sat(input int x);
      return (x > MAXV) ? MAXV : x;
   endfunction

   task automatic model_rise();
      exp_t e;
      int   p, h;
      if (armed) begin
         p = tick - last_rise;
         h = last_fall - last_rise;
         if (p > MAXV) exp_ovf = 1;
         e.p = sat(p);
         e.h = sat(h);
         if (stalled && stall_busy) exp_ovr = 1;
         else begin
            q.push_back(e);
            if (stalled) stall_busy = 1;
         end
      end
      armed     = 1;
      last_rise = tick;
   endtask

   task automatic model_fall();
      if (armed) begin
         last_fall = tick;
         if (tick - last_rise > MAXV) exp_ovf = 1;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge ip1);
         #1;
      end
   endtask

   task automatic set_sig(input logic v);
      if (v && !sig_in) model_rise();
      else if (!v && sig_in) model_fall();
      sig_in = v;
   endtask

   task automatic wave(input int h, input int l);
      set_sig(1'b1);
      cyc(h);
      set_sig(1'b0);
      cyc(l);
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_overflow"}, overflow, exp_ovf);
      check({tag, "_overrun"}, overrun, exp_ovr);
   endtask

   task automatic check_zero_outputs(input string tag);
      @(negedge ip1);
      check({tag, "_valid"}, meas_valid, 0);
      check({tag, "_period"}, meas_period, 0);
      check({tag, "_high"}, meas_high, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_overrun"}, overrun, 0);
      @(posedge ip1);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         cyc(1);
         n++;
      end
      cyc(2);
      check("drain_queue_empty", q.size(), 0);
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      cyc(1);
      clr_flags = 1'b0;
      exp_ovf   = 0;
      exp_ovr   = 0;
   endtask

   // consumer: random ready with low runs of at most 3 cycles, or forced
   initial begin
      int low_run = 0;
      meas_ready = 1'b1;
      forever begin
         @(posedge ip1);
         #2;
         if (rdy_mode) meas_ready = rdy_force;
         else if (low_run >= 3 || $urandom_range(3, 0) != 0) begin
            meas_ready = 1'b1;
            low_run    = 0;
         end else begin
            meas_ready = 1'b0;
            low_run++;
         end
      end
   end

   // monitor: pops expected results on each handshake, checks hold stability
   initial begin
      logic       pv, pr;
      logic [7:0] pp, ph;
      exp_t       e;
      pv = 1'b0; pr = 1'b0; pp = '0; ph = '0;
      forever begin
         @(negedge ip1);
         if (pv && !pr && meas_valid && !reset) begin
            check("hold_period", meas_period, pp);
            check("hold_high", meas_high, ph);
         end
         if (meas_valid && meas_ready) begin
            if (q.size() == 0) fail_now("unexpected_output");
            else begin
               e = q.pop_front();
               check("period", meas_period, e.p);
               check("high", meas_high, e.h);
            end
         end
         pv = meas_valid; pr = meas_ready; pp = meas_period; ph = meas_high;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int vc;
      sig_in    = 1'b0;
      reset     = 1'b1;
      clr_flags = 1'b0;
      cyc(3);
      check_zero_outputs("reset");
      reset = 1'b0;
      cyc(3);

      // basic 16/8 wave, always-ready consumer
      rdy_mode = 1; rdy_force = 1'b1;
      cyc(1);
      repeat (5) wave(8, 8);
      set_sig(1'b1);
      vc = 0;
      repeat (8) begin
         @(negedge ip1);
         vc += int'(meas_valid);
         @(posedge ip1);
         #1;
      end
      check("valid_pulse_cycles", vc, 1);
      set_sig(1'b0);
      cyc(8);
      check_flags("t1");
      rdy_mode = 0;

      // divider-like 64/32, then duty 3/16
      repeat (3) wave(32, 32);
      repeat (3) wave(3, 13);
      check_flags("t2");

      // period 300 saturates, sticky until clr_flags
      wave(150, 150);
      wave(8, 8);
      check_flags("t3_set");
      cyc(20);
      check_flags("t3_sticky");
      pulse_clr();
      check_flags("t3_clr");
      wave(8, 8);
      wave(8, 8);
      check_flags("t3_after");

      // consumer stalled across captures: hold first, drop the rest
      drain();
      rdy_mode = 1; rdy_force = 1'b0;
      stalled = 1; stall_busy = 0;
      cyc(1);
      repeat (3) wave(10, 6);
      check("t4_valid_held", meas_valid, 1);
      check_flags("t4");
      stalled = 0; stall_busy = 0;
      rdy_mode = 0;
      drain();

      // capture coincident with handshake: new data loads, no overrun
      pulse_clr();
      rdy_mode = 1; rdy_force = 1'b0;
      stalled = 1; stall_busy = 0;
      cyc(1);
      wave(10, 6);
      stalled = 0; stall_busy = 0;
      set_sig(1'b1);
      cyc(2);
      rdy_force = 1'b1;
      cyc(1);
      rdy_force = 1'b0;
      cyc(7);
      set_sig(1'b0);
      cyc(6);
      check("t5_valid_kept", meas_valid, 1);
      check_flags("t5");
      rdy_mode = 0;
      drain();

      // clr_flags in the same cycle as a drop: set wins
      pulse_clr();
      rdy_mode = 1; rdy_force = 1'b0;
      stalled = 1; stall_busy = 0;
      cyc(1);
      wave(10, 6);
      set_sig(1'b1);
      cyc(2);
      clr_flags = 1'b1;
      cyc(1);
      clr_flags = 1'b0;
      exp_ovf = 0;
      cyc(6);
      set_sig(1'b0);
      cyc(6);
      check_flags("t6");
      stalled = 0; stall_busy = 0;
      rdy_mode = 0;
      drain();

      // reset mid-period
      set_sig(1'b1);
      cyc(8);
      set_sig(1'b0);
      cyc(5);
      drain();
      reset = 1'b1;
      armed = 0; exp_ovf = 0; exp_ovr = 0;
      cyc(2);
      check_zero_outputs("t7_in_reset");
      reset = 1'b0;
      cyc(3);
      check_zero_outputs("t7_after");
      wave(12, 9);
      wave(12, 9);
      wave(5, 5);
      check_flags("t7");

      // random waves against the model
      repeat (40) wave($urandom_range(40, 3), $urandom_range(40, 3));
      set_sig(1'b1);
      cyc(10);
      set_sig(1'b0);
      cyc(5);
      drain();
      check_flags("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Downstream consumer of the clock-divider stage; accepts a slow square wave such as the divider's toggling output.
- Measures, in fast-clock cycles, the full period and the high time of each cycle of that wave.
- Presents each measurement on a registered valid/ready output with sticky overflow and overrun flags.
- Used to verify divider ratios and to feed period data to downstream control logic.

Parameters:
- CNT_W, 8, width of period/high counters and outputs; max count 2^CNT_W-1.
- SYNC_STAGES, 2, synchronizer flops on sig_in (legal range 2..4).

Ports:
- ip1  input  1  measurement clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  measured signal; asynchronous to ip1.
- meas_ready  input  1  consumer accepts the measurement.
- clr_flags  input  1  clears sticky flags, 1-cycle pulse.
- meas_valid  output  1  measurement available.
- meas_period  output  CNT_W  rise-to-rise period in ip1 cycles.
- meas_high  output  CNT_W  rise-to-fall high time in ip1 cycles.
- overflow  output  1  sticky; a count saturated.
- overrun  output  1  sticky; a measurement was dropped.

Behaviour:
- Clock and reset: one clock, ip1; reset is synchronous and active-high. All state updates on posedge ip1.
- Reset values: meas_valid=0, meas_period=0, meas_high=0, overflow=0, overrun=0, state=ST_IDLE, cnt=0, high_hold=0. The synchronizer chain and previous-sample flop are also cleared to 0.
- Reset mid-measurement discards any partial count. The first rising edge after reset only arms the block.
- Sync/edge detect:
  - sig_in passes through SYNC_STAGES flops, giving s.
  - rise = s & ~s_prev; fall = ~s & s_prev.
  - Latency from a sig_in change to rise/fall is SYNC_STAGES+1 cycles.
- ST_IDLE: ignores fall. On rise: cnt<=0, go to ST_MEAS. No output is produced.
- ST_MEAS, every cycle: cnt<=cnt+1, saturating at 2^CNT_W-1.
- ST_MEAS on fall: high_hold<=sat(cnt+1). If cnt is already at max, set overflow.
- ST_MEAS on rise:
  - Capture period=sat(cnt+1) and high=high_hold.
  - cnt<=0; stay in ST_MEAS.
  - If cnt is at max, set overflow.
  - A wave with edges every P cycles yields period=P.
- sat(x) is min(x, 2^CNT_W-1) computed at CNT_W+1 bits; outputs never wrap.
- Output register:
  - A capture loads meas_period/meas_high and sets meas_valid on the next edge. Latency is 1 cycle after the rise-detect cycle.
  - meas_valid holds with data stable until meas_valid&meas_ready. On that handshake with no capture in the same cycle, meas_valid<=0.
  - Capture with meas_valid=0: load.
  - Capture with meas_valid=1 and meas_ready=1 in the same cycle: load the new data; meas_valid stays 1.
  - Capture with meas_valid=1 and meas_ready=0: drop the new data, keep the old, set overrun.
- Flags: overflow and overrun are cleared only by reset or clr_flags. If a set event and clr_flags occur in the same cycle, the set wins.
- A glitch shorter than one ip1 period may be missed. This is acceptable; no filtering is applied.

Decomposition:
- Shared package period_meter_pkg holds:
  - state enum {ST_IDLE, ST_MEAS};
  - default constants PM_CNT_W=8 and PM_SYNC_STAGES=2;
  - a saturation-max helper constant.
- One sub-module, sync_edge_det, contains the SYNC_STAGES synchronizer, the s_prev flop and the rise/fall outputs. It has the same ip1/reset convention.
- Counters, FSM and output register remain in the top.

Test Plan:
- Square wave period 16, high 8, meas_ready=1: first rise produces no output. Every later rise gives meas_period=16, meas_high=8, and meas_valid pulses 1 cycle at rise-detect+1.
- Driven by the divider with N=7, on a clock at ip1/4: period 64, high 32. Then duty 3/16: high=3, period=16.
- Period 300 with CNT_W=8: meas_period=255, overflow=1 and stays 1. clr_flags clears it; a following period 16 reports 16 with overflow=0.
- meas_ready=0 across two captures: the first data is held stable and the second is dropped with overrun=1. Capture coincident with a ready handshake: the new data loads, meas_valid stays 1, no overrun.
- reset asserted mid-period, then released: all outputs 0. The next rise only arms; the following rise reports the correct period.
- clr_flags in the same cycle as an overrun event: overrun reads 1 afterwards (set wins).
